// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default sizes, writer FSM states, pixel clamp.
package conv_pkg;

    localparam int unsigned DEF_IMG_SIZE = 256;
    localparam int unsigned DEF_PX_IN_W  = 12;

    typedef enum logic {IDLE, WRITE} writerState_e;

    function automatic int unsigned out_size(input int unsigned img);
        return img - 2;
    endfunction

    // Saturate a signed filtered pixel into the unsigned 8-bit range.
    function automatic logic [7:0] clamp_u8(input logic signed [DEF_PX_IN_W-1:0] px);
        if (px[DEF_PX_IN_W-1])
            return 8'd0;
        else if (|px[DEF_PX_IN_W-2:8])
            return 8'hFF;
        else
            return px[7:0];
    endfunction

endpackage

// File: rtl/out_image_ram.sv
// Simple dual-port output image RAM: one write port, one registered read port (read-before-write).
module out_image_ram #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [7:0]        wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [7:0]        rdData
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn)
            mem[IDX_W'(wrAddr)] <= wrData;
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst)
            rdData <= '0;
        else
            rdData <= mem[IDX_W'(rdAddr)];
    end

endmodule

// File: rtl/filtered_image_writer.sv
// Writes a stream of filtered pixels in raster order into the output image RAM.
// Build option: CONV_WRITER_CLAMP_EN saturates pixels to 0..255 instead of truncating.
module filtered_image_writer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_SIZE = DEF_IMG_SIZE,
    parameter int unsigned PX_IN_W  = DEF_PX_IN_W,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PX_IN_W-1:0] px_in,
    input  logic               px_valid,
    output logic               px_ready,
    output logic               busy,
    output logic               frame_done,
    output logic [ADDR_W:0]    wr_count,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [7:0]         rd_data
);

    localparam int unsigned OUT_SIZE = out_size(IMG_SIZE);
    localparam int unsigned OUT_PIX  = OUT_SIZE * OUT_SIZE;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_SIZE - 1);

    writerState_e      state;
    logic [ADDR_W-1:0] rowCnt;
    logic [ADDR_W-1:0] colCnt;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        pxByte;
    logic              handshake;

    assign handshake = (state == WRITE) && px_valid && px_ready;

`ifdef CONV_WRITER_CLAMP_EN
    assign pxByte = clamp_u8(px_in);
`else
    logic unusedPxHi;
    assign pxByte     = px_in[7:0];
    assign unusedPxHi = ^px_in[PX_IN_W-1:8];
`endif

    // Frame FSM with registered handshake/status outputs and a running write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            px_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            wr_count   <= '0;
            rowCnt     <= '0;
            colCnt     <= '0;
            wrAddr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rowCnt     <= '0;
                        colCnt     <= '0;
                        wrAddr     <= '0;
                        wr_count   <= '0;
                        frame_done <= 1'b0;
                        busy       <= 1'b1;
                        px_ready   <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (handshake) begin
                        wrAddr   <= wrAddr + 1'b1;
                        wr_count <= wr_count + 1'b1;
                        if (colCnt == LAST_IDX) begin
                            colCnt <= '0;
                            rowCnt <= rowCnt + 1'b1;
                        end else begin
                            colCnt <= colCnt + 1'b1;
                        end
                        if ((rowCnt == LAST_IDX) && (colCnt == LAST_IDX)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            px_ready   <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    out_image_ram #(
        .DEPTH  (OUT_PIX),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (handshake),
        .wrAddr (wrAddr),
        .wrData (pxByte),
        .rdAddr (rd_addr),
        .rdData (rd_data)
    );

endmodule

// File: tb/tb_filtered_image_writer.sv
// Directed bench for filtered_image_writer at IMG_SIZE=4 (2x2 output frame).
module tb_filtered_image_writer;

    localparam int unsigned IMG_SIZE = 4;
    localparam int unsigned PX_IN_W  = 12;
    localparam int unsigned ADDR_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [PX_IN_W-1:0] px_in;
    logic               px_valid;
    logic               px_ready;
    logic               busy;
    logic               frame_done;
    logic [ADDR_W:0]    wr_count;
    logic [ADDR_W-1:0]  rd_addr;
    logic [7:0]         rd_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [PX_IN_W-1:0] px;
        logic [7:0]                expByte;
    } vec_t;

    vec_t vec [8];

    filtered_image_writer #(
        .IMG_SIZE (IMG_SIZE),
        .PX_IN_W  (PX_IN_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .px_in      (px_in),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .wr_count   (wr_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sendPixel(input logic [PX_IN_W-1:0] v);
        px_in    = v;
        px_valid = 1'b1;
        tick();
        px_valid = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        vec[0] = '{12'sd10, 8'd10};
        vec[1] = '{12'sd20, 8'd20};
        vec[2] = '{12'sd30, 8'd30};
        vec[3] = '{12'sd40, 8'd40};
`ifdef CONV_WRITER_CLAMP_EN
        vec[4] = '{-12'sd3,  8'd0};
        vec[5] = '{12'sd300, 8'd255};
`else
        vec[4] = '{-12'sd3,  8'd253};
        vec[5] = '{12'sd300, 8'd44};
`endif
        vec[6] = '{12'sd128, 8'd128};
        vec[7] = '{12'sd255, 8'd255};

        rst = 1'b1; start = 1'b0; px_in = '0; px_valid = 1'b0; rd_addr = '0;
        tick();
        check("rst_rd_data", 32'(rd_data), 0);
        tick();
        check("rst_px_ready", 32'(px_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        rst = 1'b0;

        // Valid pixel in IDLE is ignored.
        px_in = 12'd7; px_valid = 1'b1;
        tick(); tick();
        px_valid = 1'b0;
        check("idle_wr_count", 32'(wr_count), 0);
        check("idle_px_ready", 32'(px_ready), 0);

        // Table-driven full frames: plain values, then clamp/wrap values.
        for (int f = 0; f < 2; f++) begin
            pulseStart();
            check($sformatf("f%0d_busy", f), 32'(busy), 1);
            check($sformatf("f%0d_ready", f), 32'(px_ready), 1);
            check($sformatf("f%0d_done_clr", f), 32'(frame_done), 0);
            for (int i = 0; i < 4; i++)
                sendPixel(vec[f*4+i].px);
            check($sformatf("f%0d_done", f), 32'(frame_done), 1);
            check($sformatf("f%0d_busy_end", f), 32'(busy), 0);
            check($sformatf("f%0d_ready_end", f), 32'(px_ready), 0);
            check($sformatf("f%0d_wr_count", f), 32'(wr_count), 4);
            for (int i = 0; i < 4; i++)
                readCheck($sformatf("f%0d_rd%0d", f, i), ADDR_W'(i), vec[f*4+i].expByte);
        end

        // Sticky done and no writes in IDLE after a frame.
        sendPixel(12'd9);
        tick();
        check("post_done_sticky", 32'(frame_done), 1);
        check("post_wr_count", 32'(wr_count), 4);
        readCheck("post_rd0", '0, vec[4].expByte);

        // Backpressure gaps; addr 0 read in the same cycle as its write returns old data.
        pulseStart();
        rd_addr = '0;
        sendPixel(12'd5);
        check("rbw_old", 32'(rd_data), 32'(vec[4].expByte));
        px_in = 12'd99; tick();
        sendPixel(12'd6);
        px_in = 12'd99; tick();
        check("bp_wr_count", 32'(wr_count), 2);
        check("bp_busy", 32'(busy), 1);
        check("bp_done", 32'(frame_done), 0);
        readCheck("bp_rd0", 16'd0, 8'd5);
        readCheck("bp_rd1", 16'd1, 8'd6);

        // Reset mid-frame after 2 of 4 pixels.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(px_ready), 0);
        check("mid_rst_wr_count", 32'(wr_count), 0);
        readCheck("mid_rst_rd0", 16'd0, 8'd5);
        readCheck("mid_rst_rd1", 16'd1, 8'd6);
        pulseStart();
        sendPixel(12'd1); sendPixel(12'd2); sendPixel(12'd3); sendPixel(12'd4);
        check("after_rst_done", 32'(frame_done), 1);
        check("after_rst_wr_count", 32'(wr_count), 4);
        readCheck("after_rst_rd3", 16'd3, 8'd4);

        // start while busy is ignored.
        pulseStart();
        sendPixel(12'd50);
        pulseStart();
        check("ign_start_busy", 32'(busy), 1);
        check("ign_start_wr_count", 32'(wr_count), 1);
        sendPixel(12'd60); sendPixel(12'd70); sendPixel(12'd80);
        check("ign_start_done", 32'(frame_done), 1);
        check("ign_start_cnt", 32'(wr_count), 4);
        readCheck("ign_rd0", 16'd0, 8'd50);
        readCheck("ign_rd1", 16'd1, 8'd60);
        readCheck("ign_rd2", 16'd2, 8'd70);
        readCheck("ign_rd3", 16'd3, 8'd80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filtered_image_writer.md
Name: filtered_image_writer

Overview:
- Back end of the convolution datapath.
- Accepts a stream of filtered pixels, one per 3x3 window, from the filter core.
- Clamps each pixel to 8 bits and writes it in raster order into an internal (IMG_SIZE-2)x(IMG_SIZE-2) output image RAM.
- Flags frame completion and exposes a registered read-back port for dump/verification.

Parameters:
- IMG_SIZE, 256, input image edge length; output edge OUT_SIZE = IMG_SIZE-2 (valid 3x3 windows only)
- PX_IN_W, 12, width of signed filtered pixel from filter core (two's complement)
- ADDR_W, 16, output RAM address width; must satisfy 2^ADDR_W >= OUT_SIZE*OUT_SIZE

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a new frame
- px_in  in  PX_IN_W  signed filtered pixel
- px_valid  in  1  px_in valid
- px_ready  out  1  writer can accept px_in this cycle
- busy  out  1  frame write in progress
- frame_done  out  1  sticky; full frame written
- wr_count  out  ADDR_W+1  pixels written in current frame
- rd_addr  in  ADDR_W  read-back address
- rd_data  out  8  output RAM word at rd_addr, one cycle later

Behaviour:
- Reset values: px_ready=0, busy=0, frame_done=0, wr_count=0, rd_data=0. The row and column counters are cleared to 0. RAM contents are not cleared.
- FSM states: IDLE, WRITE.
- IDLE:
  - px_ready=0.
  - On start: clear row, col and wr_count; clear frame_done; go to WRITE next cycle.
- WRITE:
  - busy=1, px_ready=1.
  - Handshake completes on a cycle with px_valid && px_ready.
  - On handshake: write RAM[row*OUT_SIZE+col] = clamp(px_in); increment wr_count; col++.
  - When col==OUT_SIZE-1: col=0, row++.
  - Handshake with row==col==OUT_SIZE-1 is the last pixel: that write completes, then next cycle state=IDLE, busy=0, px_ready=0, frame_done=1.
- px_valid while not in WRITE: ignored; no write, no counter change.
- start while in WRITE: ignored.
- start in the same cycle frame_done is set: frame_done is not relevant there, since start is only sampled in IDLE.
- Address: computed with a running address register, incremented per handshake. No multiplier.
- Width rules:
  - Without CLAMP_EN the default is truncation: the low 8 bits of px_in.
  - "clamp" throughout refers to the optional-feature function below.
- Read-back:
  - Synchronous read: rd_data <= RAM[rd_addr] every cycle, latency 1.
  - Same-address read and write in one cycle returns the old data (read-before-write).
  - rd_addr >= OUT_SIZE*OUT_SIZE returns an undefined value; the bench must not check it.
- Reset mid-frame (rst during WRITE): next cycle IDLE with all outputs at reset values. Partially written RAM is retained.
- wr_count saturates naturally at OUT_SIZE*OUT_SIZE because no writes occur outside WRITE.

Optional Feature:
- Macro: CONV_WRITER_CLAMP_EN.
- Defined: each pixel is saturated before the write.
  - px_in<0 -> 0.
  - px_in>255 -> 255.
  - Otherwise px_in[7:0].
- Undefined: px_in[7:0] is written unmodified (wrap-around).
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package conv_pkg holds:
  - IMG_SIZE and PX_IN_W defaults.
  - Function out_size(img) = img-2.
  - The writer state enum {IDLE, WRITE}.
  - Function clamp_u8(signed PX_IN_W) -> 8 bits.
- One sub-module: out_image_ram, a simple dual-port RAM with one write port and one registered read port. Depth OUT_SIZE*OUT_SIZE, width 8.
- FSM, counters and clamp logic stay in filtered_image_writer.

Test Plan:
- Reset/idle (IMG_SIZE=4, so OUT_SIZE=2): hold rst 2 cycles. Require px_ready=0, busy=0, frame_done=0, wr_count=0. px_valid=1 with px_in=7 in IDLE -> wr_count stays 0.
- Full frame: start, then 4 back-to-back valid pixels 10,20,30,40. Require frame_done=1 and busy=0 the cycle after the 4th handshake, and wr_count=4. Read-back addr 0..3 gives 10,20,30,40 with 1-cycle latency.
- Backpressure gaps: px_valid toggles 1,0,1,0 with values 5,99,6,99 (the 99s are presented while px_valid=0). Only 5 and 6 are written, at addr 0 and 1; wr_count=2, busy=1.
- Clamp, CONV_WRITER_CLAMP_EN defined: px_in -3, 300, 128, 255 -> RAM 0, 255, 128, 255. Without the macro: 253, 44, 128, 255.
- Reset mid-frame: after 2 of 4 pixels, assert rst. Require busy=0, wr_count=0. Addr 0..1 retain their data. A new start plus 4 pixels completes normally with frame_done=1.
- start ignored while busy: pulse start after pixel 1. Row/col are not reset; the remaining 3 pixels land at addr 1..3.
